vga_fb_scanout: RTL and testbench
=================================

# vga_fb_scanout

Frame-buffer scan-out engine: generates VGA raster timing and fetches pixels from the dual-port frame-buffer RAM's read port in raster order. It drives the RAM's read enable, read address and output-register enable. It also absorbs the RAM's two-cycle registered read latency so that `pixel_out`, `hsync`, `vsync` and `de` leave the block mutually aligned. It sits between the frame-buffer RAM and the board VGA pins; the drawing logic owns the RAM write port.

## Interface
- `PIX_W`, 1: pixel word width; equals the RAM word width.
- `FB_W`, 160: frame-buffer width in stored pixels.
- `FB_H`, 120: frame-buffer height in stored pixels.
- `SCALE_LOG2`, 2: each stored pixel covers a 2^SCALE_LOG2 × 2^SCALE_LOG2 screen block. `FB_W<<SCALE_LOG2` must equal `H_ACTIVE`, and `FB_H<<SCALE_LOG2` must equal `V_ACTIVE`.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in ticks.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.
- `ADDR_W`, clog2(FB_W*FB_H) (15 at defaults): RAM address width.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pix_tick` in 1: pixel-rate clock enable (one `clk` in four at 100 MHz).
- `ram_read_en` out 1: RAM read enable.
- `ram_output_en` out 1: RAM output-register enable.
- `ram_output_rst` out 1: RAM output-register reset.
- `ram_read_addr` out ADDR_W: RAM read address.
- `ram_word` in PIX_W: RAM output-register data.
- `pixel_out` out PIX_W: pixel to the DAC/pins; zero outside the active area.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `de` out 1: display enable; high on active pixels.
- `frame_start` out 1: one-`clk` pulse when the first active pixel of a frame is presented.

## Operation
- Counters:
  - `x` runs 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800).
  - `y` runs 0..V_TOTAL-1 (V_TOTAL = 525).
  - Both advance only on `clk` edges where `pix_tick`=1.
  - `x` wraps to 0 at H_TOTAL-1 and `y` increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- Raw raster signals, evaluated at the counter stage:
  - `act` = (x<H_ACTIVE) && (y<V_ACTIVE).
  - `hs` is low for H_ACTIVE+H_FP ≤ x ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - `vs` is low for V_ACTIVE+V_FP ≤ y ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491).
- Address generation is incremental; no multiplier is used:
  - Row base `rb` starts at 0.
  - Within the active region the address is `rb + (x>>SCALE_LOG2)`.
  - At the end of an active line whose low SCALE_LOG2 bits of y are all 1, `rb += FB_W`.
  - At frame wrap, `rb` returns to 0.
  - `ram_read_addr` is held at the last active address during blanking. It never exceeds FB_W*FB_H-1.
- RAM control:
  - `ram_read_en` = `ram_output_en` = `pix_tick`, so the RAM pipeline advances in lockstep with the counters.
  - `ram_output_rst` = 0 during normal operation and 1 while `rst_n`=0.
- Alignment pipeline:
  - `act`, `hs`, `vs` and the frame-start condition (x=0, y=0) each pass through two registers enabled by `pix_tick`.
  - The outputs of these registers drive `de`, `hsync`, `vsync` and `frame_start`.
  - `frame_start` is gated with `pix_tick` so that it lasts one `clk`.
- `pixel_out` = `de` ? `ram_word` : 0 (combinational).

## Timing
- Reset (async assert, sync deassert handled upstream):
  - x=y=rb=0, `ram_read_addr`=0.
  - `hsync`=`vsync`=1, `de`=0, `pixel_out`=0, `frame_start`=0.
  - Pipeline registers are cleared to the inactive state.
- Latency: counter position (x,y) at tick k appears on all outputs at tick k+2. Address and data are exact: `pixel_out` at tick k+2 = RAM[addr(x,y)].
- `pix_tick`=0: every register holds and the RAM is not enabled; outputs are frozen.
- Reset mid-frame: all state clears immediately. After `rst_n` rises, scan restarts at (0,0), and the first `frame_start` occurs 2 ticks after the first tick.
- RAM writes from the drawing side in the same cycle as a read of the same address return the old data. This is acceptable and is not compensated.
- The `hsync` pulse is exactly H_SYNC ticks wide per line. `vsync` is exactly V_SYNC lines wide, asserted from x=0 of line 490 (delayed 2 ticks).

## Test plan
- Reset: hold `rst_n`=0 with `pix_tick` toggling -> `hsync`=`vsync`=1, `de`=0, `pixel_out`=0, `ram_read_addr`=0, `ram_output_rst`=1.
- Address sequence with SCALE_LOG2=2:
  - ticks x=0..7 of line 0 -> addr 0,0,0,0,1,1,1,1.
  - line 3 x=0 -> addr 0.
  - line 4 x=0 -> addr 160.
  - line 479 x=639 -> addr 19199.
- Sync timing: `hsync` falls 658 ticks after line start (656+2) and stays low 96 ticks. `vsync` is low for exactly 1600 ticks (2 lines). One frame = 420000 ticks between `frame_start` pulses.
- Data alignment:
  - Setup: behavioural RAM model with PIX_W=12 and RAM[i]=i.
  - `pixel_out` equals (y>>2)*160+(x>>2) whenever `de`=1.
  - `pixel_out`=0 on every blanked tick.
- Clock enable: hold `pix_tick`=0 for 50 `clk` mid-line -> all outputs and the address are unchanged. The scan resumes at the same x.
- Reset mid-frame at y=300: pulse `rst_n` low for 3 `clk` -> outputs return to reset values. The next `frame_start` occurs exactly 2 ticks after restart, with addr sequence 0,0,0,0,1.

Source files
------------

// File: rtl/vga_fb_scanout_if.sv
// Frame-buffer RAM read-port bundle between the scan-out engine and the RAM.
//   ram_read_en     : read enable (address capture stage)
//   ram_output_en   : output-register enable
//   ram_output_rst  : output-register reset
//   ram_read_addr   : read address
//   ram_word        : output-register data returned by the RAM
// master = scan-out engine, slave = RAM read port.
interface vga_fb_scanout_if #(
  parameter int unsigned PIX_W  = 1,
  parameter int unsigned ADDR_W = 15
);
  logic              ram_read_en;
  logic              ram_output_en;
  logic              ram_output_rst;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [PIX_W-1:0]  ram_word;

  modport master (
    output ram_read_en,
    output ram_output_en,
    output ram_output_rst,
    output ram_read_addr,
    input  ram_word
  );

  modport slave (
    input  ram_read_en,
    input  ram_output_en,
    input  ram_output_rst,
    input  ram_read_addr,
    output ram_word
  );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA frame-buffer scan-out engine.
// Generates raster timing, fetches stored pixels in raster order from a RAM
// with a two-stage registered read, and delays the raster flags by two ticks
// so pixel data and sync/enable leave the block aligned.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   pix_tick     : pixel-rate clock enable
//   ram          : RAM read port (vga_fb_scanout_if.master)
//   pixel_out    : pixel to pins, zero outside the active area
//   hsync, vsync : active-low syncs
//   de           : display enable
//   frame_start  : one-clk pulse with the first active pixel of a frame
module vga_fb_scanout #(
  parameter int unsigned PIX_W      = 1,
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned ADDR_W     = $clog2(FB_W * FB_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_tick,
  vga_fb_scanout_if.master ram,
  output logic [PIX_W-1:0] pixel_out,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned X_W     = $clog2(H_TOTAL);
  localparam int unsigned Y_W     = $clog2(V_TOTAL);

  localparam logic [X_W-1:0] X_ACT      = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] X_ACT_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] X_HS_BEG   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] X_HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT      = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_VS_BEG   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] Y_VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_MASK     = Y_W'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  // Pipeline flag order {frame_start, vs, hs, act}; idle = syncs high.
  localparam logic [3:0] PIPE_IDLE = 4'b0110;

  logic [X_W-1:0]    r_x, w_x_nxt;
  logic [Y_W-1:0]    r_y, w_y_nxt;
  logic [ADDR_W-1:0] r_rb, w_rb_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [3:0]        r_p1, r_p2;

  logic w_act, w_hs, w_vs, w_fs;
  logic w_x_last, w_y_last, w_row_adv, w_nxt_act;

  // Raw raster flags at the counter stage.
  assign w_act    = (r_x < X_ACT) && (r_y < Y_ACT);
  assign w_hs     = ~((r_x >= X_HS_BEG) && (r_x < X_HS_END));
  assign w_vs     = ~((r_y >= Y_VS_BEG) && (r_y < Y_VS_END));
  assign w_fs     = (r_x == '0) && (r_y == '0);
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // Row base advances after the last screen line covering a stored row.
  assign w_row_adv = w_act && (r_x == X_ACT_LAST) && ((r_y & Y_MASK) == Y_MASK);

  // Next counter position, row base and read address.
  always_comb begin
    w_x_nxt    = r_x + X_W'(1);
    w_y_nxt    = r_y;
    w_rb_nxt   = r_rb;
    w_addr_nxt = r_addr;

    if (w_x_last) begin
      w_x_nxt = '0;
      w_y_nxt = w_y_last ? '0 : r_y + Y_W'(1);
    end

    if (w_x_last && w_y_last) begin
      w_rb_nxt = '0;
    end else if (w_row_adv) begin
      w_rb_nxt = r_rb + ROW_STEP;
    end

    w_nxt_act = (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
    // Blanking holds the last active address.
    if (w_nxt_act) begin
      w_addr_nxt = w_rb_nxt + ADDR_W'(w_x_nxt >> SCALE_LOG2);
    end
  end

  // Counters, address and two-tick flag delay matching the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_rb   <= '0;
      r_addr <= '0;
      r_p1   <= PIPE_IDLE;
      r_p2   <= PIPE_IDLE;
    end else if (pix_tick) begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_rb   <= w_rb_nxt;
      r_addr <= w_addr_nxt;
      r_p1   <= {w_fs, w_vs, w_hs, w_act};
      r_p2   <= r_p1;
    end
  end

  assign ram.ram_read_en    = pix_tick;
  assign ram.ram_output_en  = pix_tick;
  assign ram.ram_output_rst = ~rst_n;
  assign ram.ram_read_addr  = r_addr;

  assign de          = r_p2[0];
  assign hsync       = r_p2[1];
  assign vsync       = r_p2[2];
  // The delayed flag spans a whole tick period; gating trims it to one clk.
  assign frame_start = r_p2[3] & pix_tick;
  assign pixel_out   = de ? ram.ram_word : '0;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: a default-geometry instance and a reduced-geometry
// instance (same SCALE_LOG2) share clock, reset and pix_tick so full frames fit
// in a short run. Expected values come from a position-per-tick model.
module tb_vga_fb_scanout;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_tick;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;

  localparam int S_FRAME = 32 * 19;

  typedef struct {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    int   addr;
    int   pidx;
  } exp_t;

  // Reduced instance: 5x3 stored pixels, 20x12 active, H_TOTAL 32, V_TOTAL 19.
  vga_fb_scanout_if #(.PIX_W(12), .ADDR_W(4)) s_ram ();
  logic [11:0] s_pixel;
  logic        s_hsync, s_vsync, s_de, s_frame_start;

  vga_fb_scanout #(
    .PIX_W(12), .FB_W(5), .FB_H(3), .SCALE_LOG2(2),
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .ADDR_W(4)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .ram(s_ram),
    .pixel_out(s_pixel), .hsync(s_hsync), .vsync(s_vsync),
    .de(s_de), .frame_start(s_frame_start)
  );

  vga_fb_scanout_if #(.PIX_W(12), .ADDR_W(15)) f_ram ();
  logic [11:0] f_pixel;
  logic        f_hsync, f_vsync, f_de, f_frame_start;

  vga_fb_scanout #(.PIX_W(12)) u_full (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .ram(f_ram),
    .pixel_out(f_pixel), .hsync(f_hsync), .vsync(f_vsync),
    .de(f_de), .frame_start(f_frame_start)
  );

  // Two-stage registered-read RAM models.
  logic [11:0] s_mem [0:15];
  logic [11:0] s_r1, s_word, f_r1, f_word;

  always @(posedge clk) begin
    if (s_ram.ram_output_rst) begin
      s_r1   <= '0;
      s_word <= '0;
    end else begin
      if (s_ram.ram_read_en)   s_r1   <= s_mem[s_ram.ram_read_addr];
      if (s_ram.ram_output_en) s_word <= s_r1;
    end
  end
  assign s_ram.ram_word = s_word;

  // Default-geometry RAM holds RAM[i] = i.
  always @(posedge clk) begin
    if (f_ram.ram_output_rst) begin
      f_r1   <= '0;
      f_word <= '0;
    end else begin
      if (f_ram.ram_read_en)   f_r1   <= 12'(f_ram.ram_read_addr);
      if (f_ram.ram_output_en) f_word <= f_r1;
    end
  end
  assign f_ram.ram_word = f_word;

  // Expected address at tick kk and expected outputs (position of tick kk-2).
  function automatic exp_t model(input int kk, input bit full);
    exp_t m;
    int fbw, fbh, ha, hfp, hsw, va, vfp, vsw, ht, vt, x, y, p;
    if (full) begin
      fbw = 160; fbh = 120; ha = 640; hfp = 16; hsw = 96;
      va = 480; vfp = 10; vsw = 2; ht = 800; vt = 525;
    end else begin
      fbw = 5; fbh = 3; ha = 20; hfp = 3; hsw = 4;
      va = 12; vfp = 2; vsw = 2; ht = 32; vt = 19;
    end
    x = kk % ht;
    y = (kk / ht) % vt;
    if (y >= va)      m.addr = fbw * fbh - 1;
    else if (x >= ha) m.addr = (y >> 2) * fbw + ((ha - 1) >> 2);
    else              m.addr = (y >> 2) * fbw + (x >> 2);
    if (kk < 2) begin
      m.de = 1'b0; m.hs = 1'b1; m.vs = 1'b1; m.fs = 1'b0; m.pidx = -1;
    end else begin
      p = kk - 2;
      x = p % ht;
      y = (p / ht) % vt;
      m.de   = (x < ha) && (y < va);
      m.hs   = !((x >= ha + hfp) && (x < ha + hfp + hsw));
      m.vs   = !((y >= va + vfp) && (y < va + vfp + vsw));
      m.fs   = (x == 0) && (y == 0);
      m.pidx = m.de ? (y >> 2) * fbw + (x >> 2) : -1;
    end
    return m;
  endfunction

  task automatic tick_on();
    @(negedge clk);
    pix_tick = 1'b1;
    #1;
  endtask

  task automatic tick_off(input int gap);
    k++;
    if (gap > 0) begin
      @(negedge clk);
      pix_tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_tick = 1'b0;
    repeat (8) begin
      @(negedge clk);
      pix_tick = ~pix_tick;
      #1;
      checks += 6;
      if ({s_hsync, s_vsync, s_de, s_frame_start, s_ram.ram_output_rst} !== 5'b11001) begin
        errors++; $display("FAIL reset_small_flags got %b want 11001", {s_hsync, s_vsync, s_de, s_frame_start, s_ram.ram_output_rst});
      end
      if ({f_hsync, f_vsync, f_de, f_frame_start, f_ram.ram_output_rst} !== 5'b11001) begin
        errors++; $display("FAIL reset_full_flags got %b want 11001", {f_hsync, f_vsync, f_de, f_frame_start, f_ram.ram_output_rst});
      end
      if (s_pixel !== 12'd0 || f_pixel !== 12'd0) begin
        errors++; $display("FAIL reset_pixel got %0h/%0h want 0/0", s_pixel, f_pixel);
      end
      if (s_ram.ram_read_addr !== 4'd0 || f_ram.ram_read_addr !== 15'd0) begin
        errors++; $display("FAIL reset_addr got %0d/%0d want 0/0", s_ram.ram_read_addr, f_ram.ram_read_addr);
      end
      if (s_ram.ram_read_en !== pix_tick || s_ram.ram_output_en !== pix_tick) begin
        errors++; $display("FAIL reset_small_en got %b%b want %b%b", s_ram.ram_read_en, s_ram.ram_output_en, pix_tick, pix_tick);
      end
      if (f_ram.ram_read_en !== pix_tick || f_ram.ram_output_en !== pix_tick) begin
        errors++; $display("FAIL reset_full_en got %b%b want %b%b", f_ram.ram_read_en, f_ram.ram_output_en, pix_tick, pix_tick);
      end
    end
    @(negedge clk);
    pix_tick = 1'b0;
    rst_n = 1'b1;
    k = 0;
  endtask

  // Default geometry, continuous ticks over the first four-plus lines.
  task automatic test_addr_default();
    int tbl [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int hs_fall = -1;
    int hs_rise = -1;
    logic prev_hs = 1'b1;
    exp_t e;
    for (int i = 0; i < 3300; i++) begin
      tick_on();
      e = model(k, 1'b1);
      checks += 3;
      if (f_ram.ram_read_addr !== 15'(e.addr)) begin
        errors++; $display("FAIL full_addr k=%0d got %0d want %0d", k, f_ram.ram_read_addr, e.addr);
      end
      if ({f_de, f_hsync, f_vsync, f_frame_start} !== {e.de, e.hs, e.vs, e.fs}) begin
        errors++; $display("FAIL full_flags k=%0d got %b want %b", k, {f_de, f_hsync, f_vsync, f_frame_start}, {e.de, e.hs, e.vs, e.fs});
      end
      if (f_pixel !== ((e.pidx >= 0) ? 12'(e.pidx) : 12'd0)) begin
        errors++; $display("FAIL full_pixel k=%0d got %0d want %0d", k, f_pixel, (e.pidx >= 0) ? e.pidx : 0);
      end
      if (k < 8) begin
        checks++;
        if (f_ram.ram_read_addr !== 15'(tbl[k])) begin
          errors++; $display("FAIL addr_line0 k=%0d got %0d want %0d", k, f_ram.ram_read_addr, tbl[k]);
        end
      end
      if (k == 0) begin
        checks++;
        if (f_ram.ram_output_rst !== 1'b0) begin
          errors++; $display("FAIL output_rst_run got %b want 0", f_ram.ram_output_rst);
        end
      end
      if (k == 2400 || k == 3200) begin
        checks++;
        if (f_ram.ram_read_addr !== ((k == 2400) ? 15'd0 : 15'd160)) begin
          errors++; $display("FAIL addr_row_step k=%0d got %0d want %0d", k, f_ram.ram_read_addr, (k == 2400) ? 0 : 160);
        end
      end
      if (prev_hs && !f_hsync && hs_fall < 0) hs_fall = k;
      if (!prev_hs && f_hsync && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
      prev_hs = f_hsync;
      tick_off(0);
    end
    checks += 2;
    if (hs_fall != 658) begin
      errors++; $display("FAIL hsync_fall got %0d want 658", hs_fall);
    end
    if (hs_rise - hs_fall != 96) begin
      errors++; $display("FAIL hsync_width got %0d want 96", hs_rise - hs_fall);
    end
  endtask

  // Reduced geometry, random tick spacing over three frames.
  task automatic test_raster_random();
    exp_t e;
    logic [11:0] pexp;
    int fs_prev = -1;
    int period = -1;
    int hs_low = 0;
    int vs_low = 0;
    int de_cnt = 0;
    bit counting = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      tick_on();
      e = model(k, 1'b0);
      pexp = (e.pidx >= 0) ? s_mem[e.pidx] : 12'd0;
      checks += 4;
      if (s_ram.ram_read_addr !== 4'(e.addr)) begin
        errors++; $display("FAIL small_addr k=%0d got %0d want %0d", k, s_ram.ram_read_addr, e.addr);
      end
      if (s_ram.ram_read_addr > 4'd14) begin
        errors++; $display("FAIL small_addr_max k=%0d got %0d want <=14", k, s_ram.ram_read_addr);
      end
      if ({s_de, s_hsync, s_vsync, s_frame_start} !== {e.de, e.hs, e.vs, e.fs}) begin
        errors++; $display("FAIL small_flags k=%0d got %b want %b", k, {s_de, s_hsync, s_vsync, s_frame_start}, {e.de, e.hs, e.vs, e.fs});
      end
      if (s_pixel !== pexp) begin
        errors++; $display("FAIL small_pixel k=%0d got %0h want %0h", k, s_pixel, pexp);
      end
      if (s_frame_start) begin
        if (counting) begin
          period = k - fs_prev;
          counting = 1'b0;
          done = 1'b1;
        end else if (!done) begin
          counting = 1'b1;
          fs_prev = k;
        end
      end
      if (counting) begin
        hs_low += (s_hsync == 1'b0) ? 1 : 0;
        vs_low += (s_vsync == 1'b0) ? 1 : 0;
        de_cnt += (s_de == 1'b1) ? 1 : 0;
      end
      tick_off(int'($urandom_range(0, 3)));
    end
    checks += 4;
    if (!done || period != S_FRAME) begin
      errors++; $display("FAIL frame_period got %0d want %0d", period, S_FRAME);
    end
    if (hs_low != 19 * 4) begin
      errors++; $display("FAIL hsync_low_per_frame got %0d want %0d", hs_low, 19 * 4);
    end
    if (vs_low != 2 * 32) begin
      errors++; $display("FAIL vsync_low_ticks got %0d want %0d", vs_low, 2 * 32);
    end
    if (de_cnt != 20 * 12) begin
      errors++; $display("FAIL de_count got %0d want %0d", de_cnt, 20 * 12);
    end
  endtask

  // pix_tick held low mid-line: everything frozen, scan resumes in place.
  task automatic test_clock_enable();
    exp_t e, ef;
    logic [11:0] pexp;
    for (int i = 0; i < S_FRAME && !((k % 32 == 10) && ((k / 32) % 19 == 5)); i++) begin
      tick_on();
      tick_off(0);
    end
    @(negedge clk);
    pix_tick = 1'b0;
    e = model(k, 1'b0);
    ef = model(k, 1'b1);
    pexp = (e.pidx >= 0) ? s_mem[e.pidx] : 12'd0;
    repeat (50) begin
      #1;
      checks += 4;
      if ({s_de, s_hsync, s_vsync, s_frame_start, s_ram.ram_read_en} !== {e.de, e.hs, e.vs, 2'b00}) begin
        errors++; $display("FAIL hold_small_flags k=%0d got %b want %b", k, {s_de, s_hsync, s_vsync, s_frame_start, s_ram.ram_read_en}, {e.de, e.hs, e.vs, 2'b00});
      end
      if (s_ram.ram_read_addr !== 4'(e.addr) || s_pixel !== pexp) begin
        errors++; $display("FAIL hold_small_data k=%0d got %0d/%0h want %0d/%0h", k, s_ram.ram_read_addr, s_pixel, e.addr, pexp);
      end
      if ({f_de, f_hsync, f_vsync, f_frame_start} !== {ef.de, ef.hs, ef.vs, 1'b0}) begin
        errors++; $display("FAIL hold_full_flags k=%0d got %b want %b", k, {f_de, f_hsync, f_vsync, f_frame_start}, {ef.de, ef.hs, ef.vs, 1'b0});
      end
      if (f_ram.ram_read_addr !== 15'(ef.addr)) begin
        errors++; $display("FAIL hold_full_addr k=%0d got %0d want %0d", k, f_ram.ram_read_addr, ef.addr);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      tick_on();
      e = model(k, 1'b0);
      pexp = (e.pidx >= 0) ? s_mem[e.pidx] : 12'd0;
      checks += 2;
      if (s_ram.ram_read_addr !== 4'(e.addr) || s_pixel !== pexp) begin
        errors++; $display("FAIL resume_data k=%0d got %0d/%0h want %0d/%0h", k, s_ram.ram_read_addr, s_pixel, e.addr, pexp);
      end
      if ({s_de, s_hsync, s_vsync, s_frame_start} !== {e.de, e.hs, e.vs, e.fs}) begin
        errors++; $display("FAIL resume_flags k=%0d got %b want %b", k, {s_de, s_hsync, s_vsync, s_frame_start}, {e.de, e.hs, e.vs, e.fs});
      end
      tick_off(1);
    end
  endtask

  // Reset pulse at line 8 of the reduced raster, then restart from (0,0).
  task automatic test_mid_reset();
    int tbl [5] = '{0, 0, 0, 0, 1};
    exp_t e;
    for (int i = 0; i < S_FRAME && !((k % 32 == 7) && ((k / 32) % 19 == 8)); i++) begin
      tick_on();
      tick_off(0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      #1;
      checks += 3;
      if ({s_hsync, s_vsync, s_de, s_frame_start} !== 4'b1100 || {f_hsync, f_vsync, f_de, f_frame_start} !== 4'b1100) begin
        errors++; $display("FAIL midrst_flags got %b/%b want 1100/1100", {s_hsync, s_vsync, s_de, s_frame_start}, {f_hsync, f_vsync, f_de, f_frame_start});
      end
      if (s_ram.ram_read_addr !== 4'd0 || f_ram.ram_read_addr !== 15'd0) begin
        errors++; $display("FAIL midrst_addr got %0d/%0d want 0/0", s_ram.ram_read_addr, f_ram.ram_read_addr);
      end
      if (s_pixel !== 12'd0 || s_ram.ram_output_rst !== 1'b1) begin
        errors++; $display("FAIL midrst_pixel_rst got %0h/%b want 0/1", s_pixel, s_ram.ram_output_rst);
      end
      @(negedge clk);
      pix_tick = ~pix_tick;
    end
    pix_tick = 1'b0;
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      tick_on();
      e = model(k, 1'b0);
      checks += 3;
      if (s_frame_start !== ((k == 2) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL restart_frame_start k=%0d got %b want %b", k, s_frame_start, k == 2);
      end
      if ({s_de, s_hsync, s_vsync} !== {e.de, e.hs, e.vs}) begin
        errors++; $display("FAIL restart_flags k=%0d got %b want %b", k, {s_de, s_hsync, s_vsync}, {e.de, e.hs, e.vs});
      end
      if (f_ram.ram_read_addr !== 15'(model(k, 1'b1).addr)) begin
        errors++; $display("FAIL restart_full_addr k=%0d got %0d want %0d", k, f_ram.ram_read_addr, model(k, 1'b1).addr);
      end
      if (k < 5) begin
        checks++;
        if (s_ram.ram_read_addr !== 4'(tbl[k])) begin
          errors++; $display("FAIL restart_addr k=%0d got %0d want %0d", k, s_ram.ram_read_addr, tbl[k]);
        end
      end
      tick_off(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) s_mem[i] = 12'($urandom);
    rst_n = 1'b0;
    pix_tick = 1'b0;
    test_reset();
    test_addr_default();
    test_raster_random();
    test_clock_enable();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog k=%0d got timeout want completion", k);
    $fatal(1, "watchdog expired");
  end

endmodule
